// File: rtl/cast_injector_if.sv
// Handshake bundle between the compute tile / router port and cast_injector.
interface cast_injector_if #(
  parameter int VN = 4,
  parameter int DW = 8
);
  logic [VN-1:0][DW-1:0] data_i;
  logic [VN-1:0]         valid_i;
  logic [VN-1:0]         ready_o;
  logic [VN-1:0]         vc_o;
  logic [DW-1:0]         data_o;
  logic                  valid_o;
  logic                  ready_i;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, vc_o, data_o, valid_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, vc_o, data_o, valid_o
  );
endinterface

// File: rtl/cast_injector.sv
// cast_injector: per-VC FIFOs, round-robin arbiter and a registered output stage.
// Optional output stall counter enabled by defining CAST_INJ_STALL_CNT_EN.

module cast_inj_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  assign head  = mem[rptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module cast_injector #(
  parameter int VN         = 4,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rstn,
  cast_injector_if.slave bus
`ifdef CAST_INJ_STALL_CNT_EN
  ,output logic [31:0]   stall_cnt_o
`endif
);
  localparam int LW = (VN > 1) ? $clog2(VN) : 1;

  logic [VN-1:0]         full, empty, pop;
  logic [VN-1:0][DW-1:0] head;
  logic [LW-1:0]         last_grant, gidx, arb_idx;
  logic                  free, load, arb_hit;
  int                    arb_j;

  assign free        = !bus.valid_o || bus.ready_i;
  assign load        = free && arb_hit;
  assign bus.ready_o = ~full;

  for (genvar v = 0; v < VN; v++) begin : g_vc
    assign pop[v] = load && (gidx == LW'(v));
    cast_inj_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (bus.valid_i[v] && bus.ready_o[v]),
      .wdata (bus.data_i[v]),
      .pop   (pop[v]),
      .head  (head[v]),
      .full  (full[v]),
      .empty (empty[v])
    );
  end

  // Search starts one past the last winner; first non-empty VC wins.
  always_comb begin
    arb_hit = 1'b0;
    gidx    = '0;
    arb_j   = 0;
    arb_idx = '0;
    for (int i = 0; i < VN; i++) begin
      arb_j = int'(last_grant) + 1 + i;
      if (arb_j >= VN) arb_j = arb_j - VN;
      arb_idx = LW'(arb_j);
      if (!arb_hit && !empty[arb_idx]) begin
        arb_hit = 1'b1;
        gidx    = arb_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.valid_o <= 1'b0;
      bus.vc_o    <= '0;
      bus.data_o  <= '0;
      last_grant  <= LW'(VN - 1);
    end else if (free) begin
      if (arb_hit) begin
        bus.valid_o <= 1'b1;
        bus.vc_o    <= VN'(1) << gidx;
        bus.data_o  <= head[gidx];
        last_grant  <= gidx;
      end else begin
        bus.valid_o <= 1'b0;
      end
    end
  end

`ifdef CAST_INJ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt_o <= '0;
    else if (bus.valid_o && !bus.ready_i && (stall_cnt_o != 32'hFFFF_FFFF))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cast_injector.sv
// Bench for cast_injector: queue-level reference model checked every cycle plus directed literals.
module tb_cast_injector;
  localparam int VN    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk, rstn;
  int   checks = 0, errors = 0, cyc = 0;

  cast_injector_if #(.VN(VN), .DW(DW)) bus ();
`ifdef CAST_INJ_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_stall;
`endif

  cast_injector #(.VN(VN), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
`ifdef CAST_INJ_STALL_CNT_EN
    ,.stall_cnt_o (stall_cnt)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain queues per VC and a single output slot.
  logic [DW-1:0] mq [VN][$];
  bit            m_valid;
  logic [VN-1:0] m_vc;
  logic [DW-1:0] m_data;
  int            m_last;

  typedef struct { logic [VN-1:0] vc; logic [DW-1:0] data; int cyc; } rec_t;
  rec_t log_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int v = 0; v < VN; v++) mq[v].delete();
    m_valid = 0;
    m_vc    = '0;
    m_data  = '0;
    m_last  = VN - 1;
`ifdef CAST_INJ_STALL_CNT_EN
    m_stall = '0;
`endif
  endtask

  task automatic model_step();
    bit acc [VN];
    bit found;
    int j;
    for (int v = 0; v < VN; v++) acc[v] = bus.valid_i[v] && (mq[v].size() < DEPTH);
`ifdef CAST_INJ_STALL_CNT_EN
    if (m_valid && !bus.ready_i && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
    if (!m_valid || bus.ready_i) begin
      found = 0;
      for (int i = 0; i < VN; i++) begin
        j = (m_last + 1 + i) % VN;
        if (!found && mq[j].size() > 0) begin
          found  = 1;
          m_data = mq[j].pop_front();
          m_vc   = VN'(1) << j;
          m_last = j;
        end
      end
      m_valid = found;
    end
    for (int v = 0; v < VN; v++) if (acc[v]) mq[v].push_back(bus.data_i[v]);
  endtask

  initial begin
    reset_model();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) reset_model();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle comparison against the model, plus handshake log.
  initial forever begin
    @(negedge clk);
    chk("valid_o", bus.valid_o, m_valid);
    chk("vc_o", bus.vc_o, m_vc);
    chk("data_o", bus.data_o, m_data);
    for (int v = 0; v < VN; v++) chk("ready_o", bus.ready_o[v], mq[v].size() < DEPTH);
    if (bus.valid_o) chk("vc_onehot", $onehot(bus.vc_o), 1);
`ifdef CAST_INJ_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    if (rstn && bus.valid_o && bus.ready_i) log_q.push_back('{bus.vc_o, bus.data_o, cyc});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn = 0;
    step();
    step();
    rstn = 1;
    step();
  endtask

  logic [DW-1:0] rr_exp [6];
  logic [VN-1:0] rr_vc  [6];

  initial begin
    rstn = 0;
    bus.valid_i = '0;
    bus.data_i  = '0;
    bus.ready_i = 0;
    rr_exp = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12};
    rr_vc  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    repeat (3) step();
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_vc", bus.vc_o, 0);
    chk("rst_data", bus.data_o, 0);
    chk("rst_ready", bus.ready_o, 4'hF);
    rstn = 1;
    step();

    // Latency: 2 cycles from push edge to valid_o.
    bus.ready_i = 1;
    bus.data_i[0] = 8'hA5;
    bus.valid_i = 4'b0001;
    step();
    bus.valid_i = '0;
    chk("lat_early", bus.valid_o, 0);
    step();
    chk("lat_valid", bus.valid_o, 1);
    chk("lat_vc", bus.vc_o, 4'b0001);
    chk("lat_data", bus.data_o, 8'hA5);
    step();
    chk("lat_drop", bus.valid_o, 0);

    // Round-robin across VC0 and VC1.
    do_reset();
    bus.ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      bus.data_i[0] = 8'(k);
      bus.data_i[1] = 8'(8'h10 + k);
      bus.valid_i = 4'b0011;
      step();
    end
    bus.valid_i = '0;
    log_q.delete();
    bus.ready_i = 1;
    repeat (8) step();
    bus.ready_i = 0;
    chk("rr_count", log_q.size(), 6);
    if (log_q.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("rr_data", log_q[i].data, rr_exp[i]);
        chk("rr_vc", log_q[i].vc, rr_vc[i]);
        if (i > 0) chk("rr_nobubble", log_q[i].cyc - log_q[i-1].cyc, 1);
      end

    // Backpressure until VC0 is full.
    do_reset();
    bus.ready_i = 0;
    for (int k = 0; k < 5; k++) begin
      bus.data_i[0] = 8'(8'h20 + k);
      bus.valid_i = 4'b0001;
      step();
    end
    bus.valid_i = '0;
    chk("bp_ready0", bus.ready_o[0], 0);
    chk("bp_valid", bus.valid_o, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", bus.data_o, 8'h20);
      chk("bp_hold_vc", bus.vc_o, 4'b0001);
    end
`ifdef CAST_INJ_STALL_CNT_EN
    chk("bp_stall_cnt", stall_cnt, 8);
`endif
    log_q.delete();
    bus.ready_i = 1;
    repeat (8) step();
    chk("bp_count", log_q.size(), 5);
    if (log_q.size() == 5)
      for (int i = 0; i < 5; i++) chk("bp_order", log_q[i].data, 8'h20 + i);

    // Continuous stream on VC1 across pointer wrap.
    log_q.delete();
    for (int k = 0; k < 20; k++) begin
      bus.data_i[1] = 8'(8'h40 + k);
      bus.valid_i = 4'b0010;
      step();
      chk("wrap_ready1", bus.ready_o[1], 1);
    end
    bus.valid_i = '0;
    repeat (4) step();
    chk("wrap_count", log_q.size(), 20);
    if (log_q.size() == 20)
      for (int i = 0; i < 20; i++) begin
        chk("wrap_order", log_q[i].data, 8'h40 + i);
        chk("wrap_vc", log_q[i].vc, 4'b0010);
      end

    // Reset while stalled with flits queued.
    do_reset();
    bus.ready_i = 0;
    for (int k = 0; k < 4; k++) begin
      bus.data_i[2] = 8'(8'h60 + k);
      bus.valid_i = 4'b0100;
      step();
    end
    bus.valid_i = '0;
    chk("mid_pre_valid", bus.valid_o, 1);
    #1 rstn = 0;
    #1;
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_vc", bus.vc_o, 0);
    chk("mid_rst_data", bus.data_o, 0);
    chk("mid_rst_ready", bus.ready_o, 4'hF);
    step();
    step();
    rstn = 1;
    log_q.delete();
    bus.ready_i = 1;
    repeat (6) step();
    chk("mid_no_stale", log_q.size(), 0);
    chk("mid_idle", bus.valid_o, 0);

    // Random soak; the per-cycle model checks ordering and loss.
    do_reset();
    for (int c = 0; c < 500; c++) begin
      for (int v = 0; v < VN; v++) begin
        bus.valid_i[v] = ($urandom_range(0, 2) != 0);
        bus.data_i[v]  = {2'(v), 6'(c)};
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.valid_i = '0;
    bus.ready_i = 1;
    repeat (25) step();
    chk("soak_drain_valid", bus.valid_o, 0);
    for (int v = 0; v < VN; v++) chk("soak_drain_q", mq[v].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
